// File: rtl/tdf_join_n_if.sv
// Token-stream bundle for tdf_join_n: N producer channels in, N consumer channels out.
// The master side is the producer/consumer environment; the slave side is the join block.
interface tdf_join_n_if #(
    parameter int N = 8,
    parameter int W = 16
);
    logic [N*W-1:0] in_d;
    logic [N-1:0]   in_e;
    logic [N-1:0]   in_v;
    logic [N-1:0]   in_b;
    logic [N*W-1:0] out_d;
    logic [N-1:0]   out_e;
    logic [N-1:0]   out_v;
    logic [N-1:0]   out_b;

    modport master (
        output in_d, in_e, in_v, out_b,
        input  in_b, out_d, out_e, out_v
    );

    modport slave (
        input  in_d, in_e, in_v, out_b,
        output in_b, out_d, out_e, out_v
    );
endinterface

// File: rtl/tdf_join_n.sv
// N-way all-or-nothing token join with end-of-stream propagation.
// Each output channel is buffered by its own small FIFO of {eos, data}.
module tdf_join_n #(
    parameter int N = 8,
    parameter int W = 16,
    parameter int D = 2
) (
    input  logic        clock,
    input  logic        reset,
    tdf_join_n_if.slave bus,
    output logic        fire,
    output logic        done,
    output logic        err,
    output logic [1:0]  state
);
    localparam int AW = $clog2(D);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    logic [1:0]     state_q;
    logic [1:0]     state_d;
    logic [N-1:0]   space;
    logic [N-1:0]   empty;
    logic [N-1:0]   pop;
    logic [N-1:0]   out_v_w;
    logic [N-1:0]   out_e_w;
    logic [N*W-1:0] out_d_w;
    logic           all_v;
    logic           any_e_v;
    logic           any_ne_v;
    logic           data_join;
    logic           eos_join;
    logic           mismatch;
    logic           take;

    // A token only counts when its channel is valid, so mixed flags on idle channels are ignored.
    assign all_v     = &bus.in_v;
    assign any_e_v   = |(bus.in_v & bus.in_e);
    assign any_ne_v  = |(bus.in_v & ~bus.in_e);
    assign data_join = all_v & ~any_e_v;
    assign eos_join  = all_v & ~any_ne_v;
    assign mismatch  = any_e_v & any_ne_v;

    // Space comes from registered counts only, so a pop never admits a push in the same cycle.
    assign take = ~reset && (state_q == ST_RUN) && (&space) && (data_join || eos_join);

    assign bus.in_b  = take ? '0 : '1;
    assign bus.out_v = out_v_w;
    assign bus.out_e = out_e_w;
    assign bus.out_d = out_d_w;
    assign fire      = take;
    assign done      = (state_q == ST_DONE);
    assign err       = (state_q == ST_ERR);
    assign state     = state_q;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            logic [CW-1:0] count_q;
            logic [CW-1:0] count_d;
            logic [AW-1:0] wr_ptr_q;
            logic [AW-1:0] rd_ptr_q;
            logic [W:0]    mem [D];
            logic [W:0]    head;

            assign space[gi]   = (count_q < CW'(D));
            assign empty[gi]   = (count_q == '0);
            assign out_v_w[gi] = ~empty[gi] & ~reset;
            assign pop[gi]     = out_v_w[gi] & ~bus.out_b[gi];

            // Head read is asynchronous so a token pushed into an empty queue is visible next cycle.
            assign head                 = mem[rd_ptr_q];
            assign out_d_w[gi*W +: W]   = head[W-1:0];
            assign out_e_w[gi]          = head[W];

            always_comb begin
                count_d = count_q + CW'(take) - CW'(pop[gi]);
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    count_q  <= '0;
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    count_q <= count_d;
                    if (take) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                    end
                    if (pop[gi]) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (take) begin
                    mem[wr_ptr_q] <= {bus.in_e[gi], bus.in_d[gi*W +: W]};
                end
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (take && eos_join) begin
                    state_d = ST_DRAIN;
                end else if (mismatch) begin
                    state_d = ST_ERR;
                end
            end
            ST_DRAIN: begin
                if (&empty) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end
endmodule

// File: tb/tb_tdf_join_n.sv
// Directed plus randomized bench for tdf_join_n, checked against a queue-level reference model.
module tb_tdf_join_n;
    localparam int N = 8;
    localparam int W = 16;
    localparam int D = 2;

    logic       clock;
    logic       reset;
    logic       fire;
    logic       done;
    logic       err;
    logic [1:0] state;

    tdf_join_n_if #(.N(N), .W(W)) bus ();

    tdf_join_n #(.N(N), .W(W), .D(D)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .fire  (fire),
        .done  (done),
        .err   (err),
        .state (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: per-channel queue contents (index 0 is the head) and a stream phase
    // 0 = running, 1 = draining after EOS, 2 = finished, 3 = protocol error.
    logic [W:0] qm [N][D];
    int         qn [N];
    int         mst;
    logic       m_take;
    logic       m_eos;

    task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic           all_sp;
        logic [N-1:0]   exp_ov;
        logic [N-1:0]   exp_oe;
        logic [N*W-1:0] exp_od;
        logic [N*W-1:0] dmask;
        all_sp = 1'b1;
        exp_ov = '0;
        exp_oe = '0;
        exp_od = '0;
        dmask  = '0;
        for (int i = 0; i < N; i++) begin
            if (qn[i] >= D) all_sp = 1'b0;
            if (!reset && qn[i] > 0) begin
                exp_ov[i]          = 1'b1;
                exp_oe[i]          = qm[i][0][W];
                exp_od[i*W +: W]   = qm[i][0][W-1:0];
                dmask[i*W +: W]    = '1;
            end
        end
        m_eos  = (bus.in_e == {N{1'b1}});
        m_take = !reset && (mst == 0) && (bus.in_v == {N{1'b1}}) && all_sp &&
                 ((bus.in_e == '0) || m_eos);
        chk("in_b",  N*W'(bus.in_b), m_take ? '0 : N*W'({N{1'b1}}));
        chk("fire",  N*W'(fire), N*W'(m_take));
        chk("out_v", N*W'(bus.out_v), N*W'(exp_ov));
        chk("out_e", N*W'(bus.out_e & exp_ov), N*W'(exp_oe));
        chk("out_d", bus.out_d & dmask, exp_od);
        chk("state", N*W'(state), N*W'(mst));
        chk("err",   N*W'(err), N*W'(mst == 3));
        chk("done",  N*W'(done), N*W'(mst == 2));
    endtask

    task automatic model_update();
        logic all_empty;
        if (reset) begin
            for (int i = 0; i < N; i++) qn[i] = 0;
            mst = 0;
            return;
        end
        all_empty = 1'b1;
        for (int i = 0; i < N; i++) if (qn[i] != 0) all_empty = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (qn[i] > 0 && !bus.out_b[i]) begin
                for (int k = 0; k < D - 1; k++) qm[i][k] = qm[i][k+1];
                qn[i]--;
            end
            if (m_take) begin
                qm[i][qn[i]] = {bus.in_e[i], bus.in_d[i*W +: W]};
                qn[i]++;
            end
        end
        if (m_take) $display("[TB] t=%0t join eos=%0b data0=%0h", $time, m_eos, bus.in_d[W-1:0]);
        case (mst)
            0: begin
                if (m_take && m_eos) mst = 1;
                else if ((|(bus.in_v & bus.in_e)) && (|(bus.in_v & ~bus.in_e))) mst = 3;
            end
            1: if (all_empty) mst = 2;
            default: ;
        endcase
    endtask

    // One clock: drive at the falling edge, check just after, advance the model at the rising edge.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] e, input logic [N-1:0] ob,
                        input logic rst, input bit rnd_d);
        reset      = rst;
        bus.in_v   = v;
        bus.in_e   = e;
        bus.out_b  = ob;
        for (int i = 0; i < N; i++) begin
            bus.in_d[i*W +: W] = rnd_d ? W'($urandom) : W'(i + 16'h10);
        end
        #1;
        check_all();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < N; i++) qn[i] = 0;
        mst        = 0;
        m_take     = 1'b0;
        m_eos      = 1'b0;
        reset      = 1'b1;
        bus.in_v   = '0;
        bus.in_e   = '0;
        bus.in_d   = '0;
        bus.out_b  = '0;
        @(posedge clock);
        @(negedge clock);

        // Reset state
        step(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        step(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);

        // Basic full join, then the heads appear one cycle later
        step(8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
        step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Channel 3 consumer stalled: two joins fill its queue, then everything stalls
        repeat (6) step(8'hFF, 8'h00, 8'h08, 1'b0, 1'b1);
        repeat (4) step(8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
        repeat (3) step(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);

        // Partial arrival stalls without error until the last channel shows up
        repeat (5) step(8'h7F, 8'h00, 8'h00, 1'b0, 1'b1);
        step(8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
        repeat (2) step(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);

        // Random data traffic with random back-pressure
        repeat (200) begin
            logic [N-1:0] rv;
            logic [N-1:0] rb;
            rv = ($urandom_range(0, 2) == 0) ? N'($urandom) : {N{1'b1}};
            rb = N'($urandom & $urandom);
            step(rv, 8'h00, rb, 1'b0, 1'b1);
        end

        // Reset with two tokens queued per channel discards them
        repeat (3) step(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b1);
        step(8'h00, 8'h00, 8'hFF, 1'b1, 1'b1);
        step(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);

        // End-of-stream join, drain, done held
        step(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);
        repeat (4) step(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        repeat (3) step(8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);

        // EOS mismatch: error is sticky and queued tokens still drain
        step(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        step(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b1);
        step(8'hFF, 8'h01, 8'hFF, 1'b0, 1'b1);
        repeat (3) step(8'hFF, 8'h01, 8'hFF, 1'b0, 1'b1);
        repeat (4) step(N'($urandom), N'($urandom), N'($urandom), 1'b0, 1'b1);
        repeat (2) step(8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);

        // Reset leaves the error state
        step(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        step(8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
        step(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
